// File: rtl/gpio_port_ctrl.sv
// ---------------------------------------------------------------------------
// gpio_port_ctrl
//
// Memory-mapped GPIO controller for a bank of WIDTH bidirectional pins.
// Provides data-out and direction registers, set/clear aliases for the
// data-out register, a synchronised input view, and per-pin edge-triggered
// interrupts latched in a sticky, write-1-to-clear status register.
//
// Register map (Address[4:2]):
//   0 DATA_OUT   r/w
//   1 DIR        r/w   (1 = pin driven)
//   2 DATA_IN    r     (synchronised pin value)
//   3 IRQ_EN     r/w
//   4 EDGE_SEL   r/w   (0 = rising, 1 = falling)
//   5 IRQ_STATUS r/w1c
//   6 OUT_SET    w     (DATA_OUT |= data), reads 0
//   7 OUT_CLR    w     (DATA_OUT &= ~data), reads 0
//
// Ports:
//   clk        system clock, all state on the rising edge
//   reset      asynchronous active-low reset
//   Address    byte offset within the block, [1:0] ignored
//   WriteData  bus write data, bits above WIDTH ignored
//   MemWrite   write strobe, already decoded to this block
//   ReadData   combinational read of the addressed register
//   gpio_in    asynchronous pin inputs
//   gpio_out   pin output values (DATA_OUT)
//   gpio_oe    pin output enables (DIR)
//   irq_o      level interrupt: OR of (IRQ_STATUS & IRQ_EN)
// ---------------------------------------------------------------------------
module gpio_port_ctrl #(
    parameter int WIDTH      = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4:0]            Address,
    input  logic [DATA_WIDTH-1:0] WriteData,
    input  logic                  MemWrite,
    output logic [DATA_WIDTH-1:0] ReadData,
    input  logic [WIDTH-1:0]      gpio_in,
    output logic [WIDTH-1:0]      gpio_out,
    output logic [WIDTH-1:0]      gpio_oe,
    output logic                  irq_o
);

    typedef enum logic [2:0] {
        REG_DATA_OUT   = 3'd0,
        REG_DIR        = 3'd1,
        REG_DATA_IN    = 3'd2,
        REG_IRQ_EN     = 3'd3,
        REG_EDGE_SEL   = 3'd4,
        REG_IRQ_STATUS = 3'd5,
        REG_OUT_SET    = 3'd6,
        REG_OUT_CLR    = 3'd7
    } reg_sel_e;

    // Number of cycles after reset release before edges may latch status.
    localparam logic [1:0] WARM_DONE = 2'd3;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [WIDTH-1:0] data_out_q,   data_out_d;
    logic [WIDTH-1:0] dir_q,        dir_d;
    logic [WIDTH-1:0] irq_en_q,     irq_en_d;
    logic [WIDTH-1:0] edge_sel_q,   edge_sel_d;
    logic [WIDTH-1:0] irq_status_q, irq_status_d;
    logic [WIDTH-1:0] s1_q,         s1_d;
    logic [WIDTH-1:0] s2_q,         s2_d;
    logic [WIDTH-1:0] s3_q,         s3_d;
    logic [1:0]       warm_q,       warm_d;

    // -----------------------------------------------------------------------
    // Decode and helpers
    // -----------------------------------------------------------------------
    reg_sel_e         reg_sel;
    logic [WIDTH-1:0] wr_bits;
    logic [WIDTH-1:0] w1c_mask;
    logic [WIDTH-1:0] edge_hit;
    logic [WIDTH-1:0] rd_bits;
    logic             warm_done;

    // Address[1:0] and WriteData bits above WIDTH carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^{Address[1:0], WriteData};

    assign reg_sel   = reg_sel_e'(Address[4:2]);
    assign wr_bits   = WriteData[WIDTH-1:0];
    assign warm_done = (warm_q == WARM_DONE);

    // Per-bit edge match: s2 is the current synchronised value, s3 the
    // value one cycle earlier. EDGE_SEL picks which transition counts.
    function automatic logic [WIDTH-1:0] edge_match(
        input logic [WIDTH-1:0] cur,
        input logic [WIDTH-1:0] prev,
        input logic [WIDTH-1:0] sel
    );
        logic [WIDTH-1:0] rise;
        logic [WIDTH-1:0] fall;
        rise = cur & ~prev;
        fall = ~cur & prev;
        return (rise & ~sel) | (fall & sel);
    endfunction

    // Suppressed during warm-up so pins already high at reset release do
    // not look like rising edges while the synchroniser fills.
    assign edge_hit = warm_done ? edge_match(s2_q, s3_q, edge_sel_q) : '0;

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        data_out_d = data_out_q;
        dir_d      = dir_q;
        irq_en_d   = irq_en_q;
        edge_sel_d = edge_sel_q;
        w1c_mask   = '0;

        if (MemWrite) begin
            case (reg_sel)
                REG_DATA_OUT:   data_out_d = wr_bits;
                REG_DIR:        dir_d      = wr_bits;
                REG_IRQ_EN:     irq_en_d   = wr_bits;
                REG_EDGE_SEL:   edge_sel_d = wr_bits;
                REG_IRQ_STATUS: w1c_mask   = wr_bits;
                REG_OUT_SET:    data_out_d = data_out_q | wr_bits;
                REG_OUT_CLR:    data_out_d = data_out_q & ~wr_bits;
                default:        ; // DATA_IN is read-only
            endcase
        end

        // A fresh edge overrides a simultaneous clear of the same bit.
        irq_status_d = (irq_status_q & ~w1c_mask) | edge_hit;

        s1_d = gpio_in;
        s2_d = s1_q;
        s3_d = s2_q;

        warm_d = warm_done ? WARM_DONE : warm_q + 2'd1;
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_out_q   <= '0;
            dir_q        <= '0;
            irq_en_q     <= '0;
            edge_sel_q   <= '0;
            irq_status_q <= '0;
            s1_q         <= '0;
            s2_q         <= '0;
            s3_q         <= '0;
            warm_q       <= '0;
        end else begin
            data_out_q   <= data_out_d;
            dir_q        <= dir_d;
            irq_en_q     <= irq_en_d;
            edge_sel_q   <= edge_sel_d;
            irq_status_q <= irq_status_d;
            s1_q         <= s1_d;
            s2_q         <= s2_d;
            s3_q         <= s3_d;
            warm_q       <= warm_d;
        end
    end

    // -----------------------------------------------------------------------
    // Read mux and outputs
    // -----------------------------------------------------------------------
    always_comb begin
        rd_bits = '0;
        case (reg_sel)
            REG_DATA_OUT:   rd_bits = data_out_q;
            REG_DIR:        rd_bits = dir_q;
            REG_DATA_IN:    rd_bits = s2_q;
            REG_IRQ_EN:     rd_bits = irq_en_q;
            REG_EDGE_SEL:   rd_bits = edge_sel_q;
            REG_IRQ_STATUS: rd_bits = irq_status_q;
            default:        rd_bits = '0; // set/clear aliases read as 0
        endcase
        ReadData              = '0;
        ReadData[WIDTH-1:0]   = rd_bits;
    end

    assign gpio_out = data_out_q;
    assign gpio_oe  = dir_q;
    assign irq_o    = |(irq_status_q & irq_en_q);

endmodule

// File: tb/tb_gpio_port_ctrl.sv
module tb_gpio_port_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [4:0]  Address = '0;
    logic [31:0] WriteData = '0;
    logic        MemWrite = 1'b0;
    logic [31:0] ReadData;
    logic [7:0]  gpio_in = '0;
    logic [7:0]  gpio_out;
    logic [7:0]  gpio_oe;
    logic        irq_o;

    gpio_port_ctrl #(.WIDTH(8), .DATA_WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .Address   (Address),
        .WriteData (WriteData),
        .MemWrite  (MemWrite),
        .ReadData  (ReadData),
        .gpio_in   (gpio_in),
        .gpio_out  (gpio_out),
        .gpio_oe   (gpio_oe),
        .irq_o     (irq_o)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // ---------------- reference model ----------------
    // Register images plus a short history of pin samples taken at each
    // clock edge since reset release (index 0 = most recent sample).
    logic [7:0] m_out = '0, m_dir = '0, m_en = '0, m_sel = '0, m_stat = '0;
    logic [7:0] hist[$];

    initial begin : model
        logic [7:0] det, clr, cur, prev, wd;
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) begin
                m_out = '0; m_dir = '0; m_en = '0; m_sel = '0; m_stat = '0;
                hist.delete();
            end else begin
                det = '0;
                clr = '0;
                // Edge on pin value seen two and three samples back, only
                // once three samples exist (warm-up), per EDGE_SEL.
                if (hist.size() >= 3) begin
                    cur  = hist[1];
                    prev = hist[2];
                    for (int b = 0; b < 8; b++) begin
                        if (m_sel[b] == 1'b0 && cur[b] == 1'b1 && prev[b] == 1'b0) det[b] = 1'b1;
                        if (m_sel[b] == 1'b1 && cur[b] == 1'b0 && prev[b] == 1'b1) det[b] = 1'b1;
                    end
                end
                wd = WriteData[7:0];
                if (MemWrite) begin
                    case (Address[4:2])
                        3'd0: m_out = wd;
                        3'd1: m_dir = wd;
                        3'd3: m_en  = wd;
                        3'd4: m_sel = wd;
                        3'd5: clr   = wd;
                        3'd6: m_out = m_out | wd;
                        3'd7: m_out = m_out & ~wd;
                        default: ;
                    endcase
                end
                for (int b = 0; b < 8; b++) begin
                    if (det[b]) m_stat[b] = 1'b1;
                    else if (clr[b]) m_stat[b] = 1'b0;
                end
                hist.push_front(gpio_in);
                if (hist.size() > 4) void'(hist.pop_back());
            end
        end
    end

    function automatic logic [31:0] model_read(input logic [2:0] r);
        logic [7:0] v;
        case (r)
            3'd0: v = m_out;
            3'd1: v = m_dir;
            3'd2: v = (hist.size() >= 2) ? hist[1] : 8'h00;
            3'd3: v = m_en;
            3'd4: v = m_sel;
            3'd5: v = m_stat;
            default: v = 8'h00;
        endcase
        return {24'h0, v};
    endfunction

    // ---------------- scoreboard ----------------
    // kind: 0 ReadData, 1 gpio_out, 2 gpio_oe, 3 irq_o
    int          sb_kind[$];
    logic [31:0] sb_exp[$];
    string       sb_nm[$];
    logic        obs_vld = 1'b0;

    task automatic push(input int k, input logic [31:0] e, input string nm);
        sb_kind.push_back(k);
        sb_exp.push_back(e);
        sb_nm.push_back(nm);
        obs_vld = 1'b1;
    endtask

    task automatic exp_rd(input logic [2:0] r, input logic [31:0] e, input string nm);
        Address = {r, 2'b00};
        push(0, e, nm);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        obs_vld = 1'b0;
    endtask

    task automatic wr(input logic [2:0] r, input logic [31:0] d);
        Address   = {r, 2'b00};
        WriteData = d;
        MemWrite  = 1'b1;
        @(posedge clk);
        #1;
        MemWrite  = 1'b0;
        obs_vld   = 1'b0;
    endtask

    initial begin : monitor
        int          k;
        logic [31:0] e, act;
        string       nm;
        forever begin
            @(negedge clk);
            if (obs_vld) begin
                if (sb_kind.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL scoreboard_empty: output presented with no expectation queued");
                end
                while (sb_kind.size() > 0) begin
                    k  = sb_kind.pop_front();
                    e  = sb_exp.pop_front();
                    nm = sb_nm.pop_front();
                    case (k)
                        0:       act = ReadData;
                        1:       act = {24'h0, gpio_out};
                        2:       act = {24'h0, gpio_oe};
                        default: act = {31'h0, irq_o};
                    endcase
                    checks++;
                    if (act !== e) begin
                        errors++;
                        $display("FAIL %s: got %0h expected %0h at %0t", nm, act, e, $time);
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin : stim
        logic [2:0] r;

        // Reset held with all pins high.
        reset   = 1'b0;
        gpio_in = 8'hFF;
        repeat (3) step();
        push(1, 32'h0, "rst_gpio_out");
        push(2, 32'h0, "rst_gpio_oe");
        push(3, 32'h0, "rst_irq");
        step();
        reset = 1'b1;
        step();
        exp_rd(3'd0, 32'h0, "rst_data_out"); step();
        exp_rd(3'd1, 32'h0, "rst_dir");      step();
        exp_rd(3'd3, 32'h0, "rst_irq_en");   step();
        exp_rd(3'd4, 32'h0, "rst_edge_sel"); step();
        exp_rd(3'd5, 32'h0, "rst_status");   step();
        exp_rd(3'd6, 32'h0, "rst_out_set");  step();
        exp_rd(3'd7, 32'h0, "rst_out_clr");  step();
        repeat (10) step();
        exp_rd(3'd5, 32'h0, "warmup_status"); step();
        exp_rd(3'd2, 32'hFF, "warmup_data_in"); push(3, 32'h0, "warmup_irq"); step();

        // Output register and aliases.
        wr(3'd1, 32'h0F);
        wr(3'd0, 32'hA5);
        push(1, 32'hA5, "out_a5"); push(2, 32'h0F, "oe_0f");
        exp_rd(3'd0, 32'hA5, "rd_data_out_a5");
        step();
        wr(3'd6, 32'h02);
        push(1, 32'hA7, "out_set_a7"); exp_rd(3'd6, 32'h0, "rd_out_set_zero");
        step();
        wr(3'd7, 32'h80);
        push(1, 32'h27, "out_clr_27"); exp_rd(3'd7, 32'h0, "rd_out_clr_zero");
        step();

        // Input latency and rising-edge interrupt on pin 3.
        gpio_in = 8'h00;
        repeat (4) step();
        wr(3'd3, 32'h08);
        gpio_in = 8'h08;
        exp_rd(3'd2, 32'h00, "din_before_k"); step();
        exp_rd(3'd2, 32'h00, "din_after_k"); push(3, 32'h0, "irq_after_k"); step();
        exp_rd(3'd2, 32'h08, "din_after_k1"); push(3, 32'h0, "irq_after_k1"); step();
        exp_rd(3'd5, 32'h08, "status_rise"); push(3, 32'h1, "irq_rise"); step();
        wr(3'd5, 32'h08);
        exp_rd(3'd5, 32'h00, "status_w1c"); push(3, 32'h0, "irq_w1c"); step();

        // Falling edge on pin 0 while masked.
        wr(3'd4, 32'h01);
        wr(3'd3, 32'h00);
        gpio_in = 8'h09;
        repeat (4) step();
        exp_rd(3'd5, 32'h00, "no_latch_rise_sel_fall"); step();
        gpio_in = 8'h08;
        repeat (3) step();
        exp_rd(3'd5, 32'h01, "status_fall"); push(3, 32'h0, "irq_masked"); step();
        wr(3'd3, 32'h01);
        push(3, 32'h1, "irq_unmasked"); step();

        // Edge on pin 2 detected on the same edge as a W1C of bit 2.
        wr(3'd5, 32'hFF);
        wr(3'd3, 32'h04);
        push(3, 32'h0, "irq_cleared_pre_collide");
        gpio_in = 8'h0C;
        step();
        step();
        wr(3'd5, 32'h04);
        exp_rd(3'd5, 32'h04, "collide_status"); push(3, 32'h1, "collide_irq"); step();

        // Randomised traffic against the model, with a mid-run reset.
        for (int i = 0; i < 400; i++) begin
            if (i == 200) begin
                reset = 1'b0;
                #1;
            end
            if (i == 203) reset = 1'b1;
            if ($urandom_range(3) == 0) gpio_in = 8'($urandom);
            r = 3'($urandom_range(7));
            Address = {r, 2'b00};
            if ($urandom_range(1) == 1) begin
                MemWrite  = 1'b1;
                WriteData = $urandom;
            end else begin
                MemWrite  = 1'b0;
            end
            push(0, model_read(r), "rand_rd");
            push(1, {24'h0, m_out}, "rand_out");
            push(2, {24'h0, m_dir}, "rand_oe");
            push(3, {31'h0, |(m_stat & m_en)}, "rand_irq");
            step();
        end
        MemWrite = 1'b0;
        step();

        if (sb_kind.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_kind.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
